// File: rtl/ncc_pkg.sv
// Shared NCC types: score type and width, used by the ncc stage and the peak finder.
package ncc_pkg;

    localparam int NCC_SCORE_W = 32;

    typedef logic signed [NCC_SCORE_W-1:0] score_t;

    // Strict signed compare, so a tie keeps the earlier (current) peak.
    function automatic logic score_gt(input score_t a, input score_t b);
        return (a > b);
    endfunction

endpackage

// File: rtl/ncc_pos_counter.sv
// Raster x/y position counter: x wraps at numCols-1 into y; tc flags the last position of the window.
module ncc_pos_counter #(
    parameter int numCols = 65,
    parameter int numRows = 65,
    parameter int XW      = 7,
    parameter int YW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          tc
);

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          x_last_s;
    logic          y_last_s;

    assign x_last_s = (x_r == XW'(numCols - 1));
    assign y_last_s = (y_r == YW'(numRows - 1));
    assign x        = x_r;
    assign y        = y_r;
    assign tc       = x_last_s && y_last_s;

    // Position register; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r <= '0;
            y_r <= '0;
        end else if (clr) begin
            x_r <= '0;
            y_r <= '0;
        end else if (inc) begin
            if (x_last_s) begin
                x_r <= '0;
                y_r <= y_last_s ? '0 : (y_r + YW'(1));
            end else begin
                x_r <= x_r + XW'(1);
            end
        end
    end

endmodule

// File: rtl/ncc_peak_finder.sv
// Streams one window of NCC scores in raster order and reports the strict-max peak and its position.
// Optional NCC_PEAK_THRESH_EN adds minScore and qualifies found against it.
module ncc_peak_finder
    import ncc_pkg::*;
#(
    parameter int numCols = 65,
    parameter int numRows = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scoreValid,
    input  score_t                     scoreIn,
    input  logic                       scoreLast,
    output logic                       scoreReady,
    output logic                       resultValid,
    input  logic                       resultReady,
`ifdef NCC_PEAK_THRESH_EN
    input  score_t                     minScore,
`endif
    output score_t                     peakScore,
    output logic [$clog2(numCols)-1:0] peakX,
    output logic [$clog2(numRows)-1:0] peakY,
    output logic                       errLen,
    output logic                       found
);

    localparam int XW = $clog2(numCols);
    localparam int YW = $clog2(numRows);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    state_t        state_r, state_s;
    logic          ready_r, valid_r, err_r, found_r;
    score_t        run_peak_r, peak_r;
    logic [XW-1:0] run_x_r, peak_x_r, x_s, bx_s;
    logic [YW-1:0] run_y_r, peak_y_r, y_s, by_s;
    logic          tc_s, accept_s, take_s, end_s, release_s, clr_s;
    score_t        best_s;

    assign accept_s  = scoreValid && ready_r;
    // First score of a window is taken unconditionally; the counter is at (0,0) then.
    assign take_s    = (state_r == IDLE) || score_gt(scoreIn, run_peak_r);
    assign best_s    = take_s ? scoreIn : run_peak_r;
    assign bx_s      = take_s ? x_s : run_x_r;
    assign by_s      = take_s ? y_s : run_y_r;
    assign end_s     = accept_s && (scoreLast || tc_s);
    assign release_s = (state_r == DONE) && resultReady;
    assign clr_s     = end_s || release_s;

    ncc_pos_counter #(
        .numCols(numCols),
        .numRows(numRows),
        .XW     (XW),
        .YW     (YW)
    ) u_pos (
        .clk(clk),
        .rst(rst),
        .clr(clr_s),
        .inc(accept_s),
        .x  (x_s),
        .y  (y_s),
        .tc (tc_s)
    );

    // State register and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s != DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = end_s ? DONE : SCAN;
                else          state_s = IDLE;
            end
            SCAN: begin
                if (end_s) state_s = DONE;
                else       state_s = SCAN;
            end
            DONE: begin
                if (resultReady) state_s = IDLE;
                else             state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Running peak and the result registers captured at window end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_peak_r <= '0;
            run_x_r    <= '0;
            run_y_r    <= '0;
            peak_r     <= '0;
            peak_x_r   <= '0;
            peak_y_r   <= '0;
            err_r      <= 1'b0;
            found_r    <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            if (accept_s && take_s) begin
                run_peak_r <= scoreIn;
                run_x_r    <= x_s;
                run_y_r    <= y_s;
            end
            if (end_s) begin
                peak_r   <= best_s;
                peak_x_r <= bx_s;
                peak_y_r <= by_s;
                err_r    <= scoreLast ^ tc_s;
                valid_r  <= 1'b1;
`ifdef NCC_PEAK_THRESH_EN
                found_r  <= (best_s >= minScore);
`else
                found_r  <= 1'b1;
`endif
            end else if (release_s) begin
                valid_r <= 1'b0;
                found_r <= 1'b0;
            end
        end
    end

    assign scoreReady  = ready_r;
    assign resultValid = valid_r;
    assign peakScore   = peak_r;
    assign peakX       = peak_x_r;
    assign peakY       = peak_y_r;
    assign errLen      = err_r;
    assign found       = found_r;

endmodule

// File: tb/tb_ncc_peak_finder.sv
// Scoreboard bench for ncc_peak_finder: a 3x2 and a 65x65 instance, expected results queued at drive time.
module tb_ncc_peak_finder;

    typedef struct {
        int score;
        int x;
        int y;
        bit err;
        bit fnd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [31:0] score_in = '0;
    logic score_last = 1'b0;
    logic result_ready = 1'b1;
    logic valid_s = 1'b0, valid_l = 1'b0;
    logic sr_s, sr_l, rv_s, rv_l, err_s, err_l, fnd_s, fnd_l;
    logic signed [31:0] ps_s, ps_l;
    logic [1:0] px_s;
    logic       py_s;
    logic [6:0] px_l, py_l;
`ifdef NCC_PEAK_THRESH_EN
    logic signed [31:0] min_score = 32'sd50;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int vals[$];
    exp_t q_s[$], q_l[$];
    exp_t e_s, e_l;

    always #5 clk = ~clk;

    ncc_peak_finder #(.numCols(3), .numRows(2)) dut_s (
        .clk(clk), .rst(rst), .scoreValid(valid_s), .scoreIn(score_in), .scoreLast(score_last),
        .scoreReady(sr_s), .resultValid(rv_s), .resultReady(result_ready),
`ifdef NCC_PEAK_THRESH_EN
        .minScore(min_score),
`endif
        .peakScore(ps_s), .peakX(px_s), .peakY(py_s), .errLen(err_s), .found(fnd_s)
    );

    ncc_peak_finder #(.numCols(65), .numRows(65)) dut_l (
        .clk(clk), .rst(rst), .scoreValid(valid_l), .scoreIn(score_in), .scoreLast(score_last),
        .scoreReady(sr_l), .resultValid(rv_l), .resultReady(result_ready),
`ifdef NCC_PEAK_THRESH_EN
        .minScore(min_score),
`endif
        .peakScore(ps_l), .peakX(px_l), .peakY(py_l), .errLen(err_l), .found(fnd_l)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: pop and compare on every result handshake.
    always @(negedge clk) begin
        if (rv_s && result_ready) begin
            if (q_s.size() == 0) chk("s_unexpected", 1, 0);
            else begin
                e_s = q_s.pop_front();
                chk("s_score", ps_s, e_s.score);
                chk("s_x", px_s, e_s.x);
                chk("s_y", py_s, e_s.y);
                chk("s_err", err_s, e_s.err);
                chk("s_found", fnd_s, e_s.fnd);
            end
        end
        if (rv_l && result_ready) begin
            if (q_l.size() == 0) chk("l_unexpected", 1, 0);
            else begin
                e_l = q_l.pop_front();
                chk("l_score", ps_l, e_l.score);
                chk("l_x", px_l, e_l.x);
                chk("l_y", py_l, e_l.y);
                chk("l_err", err_l, e_l.err);
                chk("l_found", fnd_l, e_l.fnd);
            end
        end
    end

    // Entered and left at posedge+1; waits for ready, then the next posedge accepts.
    task automatic send(input int sel, input int v, input bit last);
        int n;
        n = 0;
        score_in = v;
        score_last = last;
        if (sel != 0) valid_l = 1'b1; else valid_s = 1'b1;
        @(negedge clk);
        while (((sel != 0) ? sr_l : sr_s) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 0, 1);
        if (last) chk("pre_result_low", (sel != 0) ? rv_l : rv_s, 0);
        @(posedge clk);
        #1;
        valid_s = 1'b0;
        valid_l = 1'b0;
        score_last = 1'b0;
    endtask

    task automatic run_window(input int sel, input bit use_last, input bit hold);
        exp_t e;
        int cols, rows, n;
        cols = (sel != 0) ? 65 : 3;
        rows = (sel != 0) ? 65 : 2;
        n = vals.size();
        e.score = vals[0];
        e.x = 0;
        e.y = 0;
        for (int k = 1; k < n; k++) begin
            if (vals[k] > e.score) begin
                e.score = vals[k];
                e.x = k % cols;
                e.y = k / cols;
            end
        end
        e.err = !(use_last && (n == cols * rows));
`ifdef NCC_PEAK_THRESH_EN
        e.fnd = (e.score >= 50);
`else
        e.fnd = 1'b1;
`endif
        if (sel != 0) q_l.push_back(e); else q_s.push_back(e);
        if (hold) result_ready = 1'b0;
        for (int k = 0; k < n; k++) send(sel, vals[k], use_last && (k == n - 1));
        @(negedge clk);
        chk("latency", (sel != 0) ? rv_l : rv_s, 1);
        if (hold) begin
            for (int c = 0; c < 4; c++) begin
                chk("hold_valid", rv_l, 1);
                chk("hold_score", ps_l, e.score);
                chk("hold_xy", {px_l, py_l}, {e.x[6:0], e.y[6:0]});
                chk("hold_err", err_l, e.err);
                chk("hold_found", fnd_l, e.fnd);
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        result_ready = 1'b1;
    endtask

    initial begin
        int n;
        // Reset state, and ready rising one cycle after release.
        repeat (2) @(negedge clk);
        chk("rst_ready", sr_s, 0);
        chk("rst_valid", rv_s, 0);
        chk("rst_score", ps_l, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_lag", sr_s, 0);
        @(negedge clk);
        chk("ready_up", sr_s, 1);
        chk("ready_up_l", sr_l, 1);
        @(posedge clk);
        #1;

        vals = '{5, 9, -2, 9, 1, 0};
        run_window(0, 1'b1, 1'b0);
        vals = '{-5, -3, -3, -10, -4, -9};
        run_window(0, 1'b0, 1'b0);
        vals = '{7, 12};
        run_window(0, 1'b1, 1'b0);
        vals = '{42};
        run_window(0, 1'b1, 1'b0);
        vals = '{49, 10, -1, 49, 0, 3};
        run_window(0, 1'b1, 1'b0);
        vals = '{20, 50, 50, 1, 0, 3};
        run_window(0, 1'b1, 1'b0);

        // Abort mid-window on both instances, then fresh windows.
        for (int k = 0; k < 4; k++) send(0, 500, 1'b0);
        for (int k = 0; k < 10; k++) send(1, 1000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", rv_s, 0);
        chk("abort_score", ps_l, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vals = '{1, -3, 7, 2, 0, 100};
        run_window(0, 1'b1, 1'b0);
        vals = '{3, -1, 8, 2};
        run_window(1, 1'b1, 1'b0);

        vals.delete();
        for (int k = 0; k < 4225; k++) vals.push_back(-7);
        run_window(1, 1'b1, 1'b1);
        vals.delete();
        for (int k = 0; k < 4225; k++) vals.push_back(((k * 37) % 211) - 100);
        run_window(1, 1'b0, 1'b0);

        n = 0;
        while ((q_s.size() != 0 || q_l.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q_s.size() + q_l.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
